pixel_source_fifo: RTL and testbench

// Per-source pixel buffer on the requester side of the contention tree's req/ack pixel channel.
// - Stores rasterised pixels and publishes its occupancy on fill for arbitration.
// - Answers each arbiter req with a one-cycle ack and the oldest pixel on pix_out.
// - Four instances feed the contention tree, one per source slot 1..4.

---
 rtl/pixel_source_fifo.sv | 59 +++++
 tb/tb_pixel_source_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pixel_source_fifo.sv
// pixel_source_fifo: per-source pixel FIFO that answers each arbiter req pulse with a one-cycle ack and one popped pixel
module pixel_source_fifo #(
    parameter int LENGTH      = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [PIXEL_WIDTH-1:0] wr_pix,
    output logic                   full,
    output logic                   overflow,
    output logic [LENGTH-1:0]      fill,
    input  logic                   req,
    output logic                   ack,
    output logic [PIXEL_WIDTH-1:0] pix_out
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    state_t state, next_state;
    logic [PIXEL_WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic push, pop;
    assign full = fill == LENGTH'(DEPTH);
    assign ack  = state == ACK;
    always_comb begin
        push = wr_en && !full;
        pop  = state == IDLE && req && fill != '0;
        next_state = state == IDLE ? (pop ? ACK : IDLE) : state == ACK ? HOLD : (req ? HOLD : IDLE);
    end
    always_ff @(posedge clk) begin
        if (push)
            ram[wr_ptr] <= wr_pix;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
            pix_out  <= '0;
        end else begin
            state <= next_state;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pix_out <= ram[rd_ptr];
            end
            if (push && !pop)
                fill <= fill + 1'b1;
            else if (pop && !push)
                fill <= fill - 1'b1;
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_source_fifo.sv
// tb_pixel_source_fifo: directed checks of push/pop ordering, handshake timing, overflow and reset
module tb_pixel_source_fifo;
    logic       clk = 1'b0;
    logic       rst, wr_en, req;
    logic [7:0] wr_pix;
    logic       full, overflow, ack;
    logic [7:0] fill, pix_out;
    int vectors = 0;
    int miscompares = 0;

    pixel_source_fifo #(.LENGTH(8), .PIXEL_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_pix(wr_pix), .full(full),
        .overflow(overflow), .fill(fill), .req(req), .ack(ack), .pix_out(pix_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] p);
        wr_en = 1'b1;
        wr_pix = p;
        tick();
        wr_en = 1'b0;
    endtask

    // req for one cycle, check the ack and pixel, then let the FSM return to IDLE
    task automatic pop_one(input string tag, input logic [7:0] exp);
        req = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(ack), 1);
        check({tag, "_pix"}, 32'(pix_out), 32'(exp));
        req = 1'b0;
        tick();
        check({tag, "_hold_noack"}, 32'(ack), 0);
        tick();
    endtask

    initial begin
        int acks;
        rst = 1'b0; wr_en = 1'b0; req = 1'b0; wr_pix = '0;
        tick();
        push(8'h11);
        push(8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ack", 32'(ack), 0);
        check("rst_pix", 32'(pix_out), 0);
        check("rst_fill", 32'(fill), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);

        push(8'hA5);
        tick();
        req = 1'b1;
        tick();
        check("single_ack", 32'(ack), 1);
        check("single_pix", 32'(pix_out), 32'hA5);
        check("single_fill", 32'(fill), 0);
        req = 1'b0;
        tick();
        check("single_ack_drop", 32'(ack), 0);
        tick();

        for (int i = 1; i <= 4; i++) push(8'(i));
        check("wrap_full", 32'(full), 1);
        check("wrap_fill4", 32'(fill), 4);
        pop_one("wrap1", 8'd1);
        pop_one("wrap2", 8'd2);
        push(8'd5);
        push(8'd6);
        check("wrap_full2", 32'(full), 1);
        for (int i = 3; i <= 6; i++) pop_one("wrap_n", 8'(i));
        check("wrap_fill0", 32'(fill), 0);
        check("wrap_notfull", 32'(full), 0);

        for (int i = 7; i <= 10; i++) push(8'(i));
        push(8'hFF);
        check("ovf_fill", 32'(fill), 4);
        check("ovf_flag", 32'(overflow), 1);
        for (int i = 7; i <= 10; i++) pop_one("ovf_drain", 8'(i));
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_empty", 32'(fill), 0);
        req = 1'b1;
        tick();
        check("ovf_no_ff", 32'(ack), 0);
        check("ovf_pix_held", 32'(pix_out), 32'd10);
        req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        push(8'h31);
        push(8'h32);
        push(8'h33);
        req = 1'b1;
        tick();
        check("held_ack", 32'(ack), 1);
        check("held_pix", 32'(pix_out), 32'h31);
        check("held_fill", 32'(fill), 2);
        acks = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            acks += int'(ack);
        end
        check("held_extra_acks", 32'(acks), 0);
        check("held_fill_after", 32'(fill), 2);
        req = 1'b0;
        tick();
        pop_one("held_next", 8'h32);
        pop_one("held_last", 8'h33);

        req = 1'b1;
        tick();
        check("empty_noack1", 32'(ack), 0);
        tick();
        check("empty_noack2", 32'(ack), 0);
        wr_en = 1'b1;
        wr_pix = 8'h66;
        tick();
        wr_en = 1'b0;
        check("late_push_noack", 32'(ack), 0);
        check("late_push_fill", 32'(fill), 1);
        tick();
        check("late_push_ack", 32'(ack), 1);
        check("late_push_pix", 32'(pix_out), 32'h66);
        check("late_push_fill0", 32'(fill), 0);
        req = 1'b0;
        tick();
        tick();

        push(8'h70);
        wr_en = 1'b1;
        wr_pix = 8'h71;
        req = 1'b1;
        tick();
        wr_en = 1'b0;
        check("simul_ack", 32'(ack), 1);
        check("simul_pix", 32'(pix_out), 32'h70);
        check("simul_fill", 32'(fill), 1);
        req = 1'b0;
        tick();
        tick();
        pop_one("simul_next", 8'h71);
        check("final_fill", 32'(fill), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
